// File: rtl/video_pattern_generator.sv
// Avalon-ST test-pattern source: bars, ramp, scrolling checkerboard, solid; one pixel per clock.
// Latency: first pixel valid one cycle after enable is sampled in IDLE; back-to-back frames have no gap.
// Backpressure: while valid && !ready, data/sop/eop hold and no counter advances.
module video_pattern_generator #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [15:0] frame_count
);

  localparam logic [9:0] X_LAST   = 10'(WIDTH - 1);
  localparam logic [9:0] Y_LAST   = 10'(HEIGHT - 1);
  localparam logic [6:0] SUB_LAST = 7'(WIDTH / 8 - 1);

  // The frame-end decision is taken on the eop transfer edge itself, so it
  // folds into the ACTIVE exit rather than occupying a cycle of its own.
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  x, y, x_n, y_n;
  logic [2:0]  bar, bar_n;
  logic [6:0]  sub, sub_n;
  logic [1:0]  pat_q, pat_n;
  logic [23:0] solid_q, solid_n;
  logic [9:0]  fc_lo;
  logic [23:0] pix_n;
  logic        eop_n;
  logic        xfer, last_pix, frame_done;
  logic        load_first, step_pix, stop;

  assign xfer       = out_valid && out_ready;
  assign last_pix   = (x == X_LAST) && (y == Y_LAST);
  assign frame_done = xfer && last_pix;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (enable) state_nxt = ACTIVE;
      ACTIVE: if (frame_done && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_first = enable && ((state == IDLE) || frame_done);
    step_pix   = (state == ACTIVE) && xfer && !last_pix;
    stop       = (state == ACTIVE) && frame_done && !enable;
  end

  always_comb begin
    x_n     = x;
    y_n     = y;
    bar_n   = bar;
    sub_n   = sub;
    pat_n   = pat_q;
    solid_n = solid_q;
    if (load_first) begin
      x_n     = '0;
      y_n     = '0;
      bar_n   = '0;
      sub_n   = '0;
      pat_n   = pattern_sel;
      solid_n = solid_color;
    end else if (x == X_LAST) begin
      x_n   = '0;
      y_n   = y + 10'd1;
      bar_n = '0;
      sub_n = '0;
    end else begin
      x_n = x + 10'd1;
      if (sub == SUB_LAST) begin
        sub_n = '0;
        bar_n = bar + 3'd1;
      end else begin
        sub_n = sub + 7'd1;
      end
    end
    eop_n = (x_n == X_LAST) && (y_n == Y_LAST);
  end

  // A frame loaded on the eop edge must see the count that edge produces.
  assign fc_lo = frame_count[9:0] + 10'(frame_done);

  always_comb begin
    pix_n = '0;
    case (pat_n)
      2'd0: begin
        case (bar_n)
          3'd0: pix_n = 24'hFFFFFF;
          3'd1: pix_n = 24'hFFFF00;
          3'd2: pix_n = 24'h00FFFF;
          3'd3: pix_n = 24'h00FF00;
          3'd4: pix_n = 24'hFF00FF;
          3'd5: pix_n = 24'hFF0000;
          3'd6: pix_n = 24'h0000FF;
          default: pix_n = 24'h000000;
        endcase
      end
      2'd1: pix_n = {x_n[7:0], y_n[7:0], fc_lo[7:0]};
      2'd2: pix_n = (1'((x_n + fc_lo) >> 5) ^ 1'(y_n >> 5)) ? 24'hFFFFFF : 24'h000000;
      default: pix_n = solid_n;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      x                 <= '0;
      y                 <= '0;
      bar               <= '0;
      sub               <= '0;
      pat_q             <= '0;
      solid_q           <= '0;
      frame_count       <= '0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else begin
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (load_first) begin
        pat_q   <= pattern_sel;
        solid_q <= solid_color;
      end
      if (load_first || step_pix) begin
        x                 <= x_n;
        y                 <= y_n;
        bar               <= bar_n;
        sub               <= sub_n;
        out_data          <= pix_n;
        out_valid         <= 1'b1;
        out_startofpacket <= load_first;
        out_endofpacket   <= eop_n;
      end else if (stop) begin
        out_valid         <= 1'b0;
        out_startofpacket <= 1'b0;
        out_endofpacket   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_generator.sv
// Self-checking bench for video_pattern_generator (16x4 main instance, 64x2 checkerboard instance).
module tb_video_pattern_generator;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int W2 = 64;

  localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  localparam logic [23:0] LINE [0:15] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                                          24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
                                          24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
                                          24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000};

  logic        clk = 0;
  logic        reset_reset = 1;
  logic        enable = 0;
  logic [1:0]  pattern_sel = 0;
  logic [23:0] solid_color = 0;
  logic        out_ready = 1;
  logic [23:0] out_data;
  logic        out_valid, out_startofpacket, out_endofpacket;
  logic [15:0] frame_count;

  logic        en2 = 0;
  logic [1:0]  pat2 = 2'd2;
  logic [23:0] solid2 = 0;
  logic        rdy2 = 1;
  logic [23:0] d2_data;
  logic        d2_valid, d2_sop, d2_eop;
  logic [15:0] d2_fc;

  always #5 clk = ~clk;

  video_pattern_generator #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .frame_count(frame_count));

  video_pattern_generator #(.WIDTH(W2), .HEIGHT(2)) dut2 (
    .clk_clk(clk), .reset_reset(reset_reset), .enable(en2), .pattern_sel(pat2),
    .solid_color(solid2), .out_data(d2_data), .out_valid(d2_valid), .out_ready(rdy2),
    .out_startofpacket(d2_sop), .out_endofpacket(d2_eop), .frame_count(d2_fc));

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pix(int pat, logic [23:0] solid, int fc, int x, int y, int w);
    case (pat)
      0: return BARS[x / (w / 8)];
      1: return {8'(x), 8'(y), 8'(fc)};
      2: return (((((x + fc) % 1024) / 32) % 2) ^ ((y / 32) % 2)) != 0 ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  // Frame-level reference: index of the pixel on the bus plus what the frame latched.
  bit          m_valid = 0;
  int          m_idx = 0, m_fc = 0, m_ffc = 0, m_pat = 0;
  logic [23:0] m_solid = 0;

  task automatic m_start();
    m_valid = 1;
    m_idx   = 0;
    m_pat   = int'(pattern_sel);
    m_solid = solid_color;
    m_ffc   = m_fc;
  endtask

  always @(posedge clk) begin
    if (reset_reset) begin
      m_valid = 0; m_fc = 0; m_idx = 0;
    end else if (!m_valid) begin
      if (enable) m_start();
    end else if (out_ready) begin
      if (m_idx == N - 1) begin
        m_fc = (m_fc + 1) % 65536;
        if (enable) m_start();
        else m_valid = 0;
      end else begin
        m_idx++;
      end
    end
  end

  bit          chk_on = 0;
  bit          pv = 0, pr = 1, ps = 0, pe = 0;
  logic [23:0] pd = 0;
  logic [23:0] log_d[$];
  bit          log_s[$], log_e[$];
  logic [23:0] log2[$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid", out_valid, m_valid);
      check("frame_count", frame_count, m_fc);
      if (m_valid) begin
        check("data", out_data, model_pix(m_pat, m_solid, m_ffc, m_idx % W, m_idx / W, W));
        check("sop", out_startofpacket, m_idx == 0);
        check("eop", out_endofpacket, m_idx == N - 1);
      end
      if (pv && !pr) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_sop", out_startofpacket, ps);
        check("stall_eop", out_endofpacket, pe);
      end
      if (out_valid && out_ready) begin
        log_d.push_back(out_data);
        log_s.push_back(out_startofpacket);
        log_e.push_back(out_endofpacket);
      end
      if (d2_valid) log2.push_back(d2_data);
      pv = out_valid; pr = out_ready; pd = out_data;
      ps = out_startofpacket; pe = out_endofpacket;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_fc(int target, int budget);
    int n = 0;
    while (frame_count !== 16'(target) && n < budget) begin
      step(1);
      n++;
    end
    check("wait_frame_count", frame_count, target);
  endtask

  initial begin
    int n, sops, eops;
    @(posedge clk);
    #2;
    chk_on = 1;
    step(2);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sop", out_startofpacket, 0);
    check("rst_eop", out_endofpacket, 0);
    check("rst_fc", frame_count, 0);

    reset_reset = 0; enable = 1; en2 = 1; pattern_sel = 0;
    step(1);
    check("start_valid", out_valid, 1);
    check("start_sop", out_startofpacket, 1);
    check("start_data", out_data, 24'hFFFFFF);
    pattern_sel = 1;

    wait_fc(1, 200);
    sops = 0; eops = 0;
    for (int i = 0; i < W; i++) begin
      check("bars_line0", log_d[i], LINE[i]);
      check("bars_line3", log_d[3 * W + i], LINE[i]);
    end
    for (int i = 0; i < N; i++) begin
      sops += int'(log_s[i]);
      eops += int'(log_e[i]);
    end
    check("bars_sop_first", log_s[0], 1);
    check("bars_eop_last", log_e[N - 1], 1);
    check("bars_sop_count", sops, 1);
    check("bars_eop_count", eops, 1);

    wait_fc(2, 200);
    pattern_sel = 2;
    wait_fc(3, 200);
    check("ramp_f1_px5_3", log_d[N + 3 * W + 5], 24'h050301);
    check("ramp_f2_px5_3", log_d[2 * N + 3 * W + 5], 24'h050302);
    check("no_gap_xfers", log_d.size(), 3 * N);

    pattern_sel = 0;
    wait_fc(4, 200);
    n = 0;
    while (frame_count !== 16'd5 && n < 2000) begin
      out_ready = ($urandom_range(0, 9) < 3);
      step(1);
      n++;
    end
    out_ready = 1;
    check("stall_frame_done", frame_count, 5);
    for (int i = 0; i < N; i++) check("stall_seq", log_d[4 * N + i], log_d[i]);

    step(20);
    pattern_sel = 3; solid_color = 24'h123456;
    step(20);
    enable = 0;
    wait_fc(6, 200);
    step(2);
    check("idle_after_eop", out_valid, 0);
    for (int i = 0; i < N; i++) check("bars_kept", log_d[5 * N + i], log_d[i]);

    enable = 1;
    wait_fc(7, 200);
    for (int i = 0; i < N; i++) check("solid_frame", log_d[6 * N + i], 24'h123456);

    pattern_sel = 1;
    step(30);
    reset_reset = 1;
    step(1);
    check("midrst_valid", out_valid, 0);
    check("midrst_fc", frame_count, 0);
    reset_reset = 0;
    step(1);
    check("restart_valid", out_valid, 1);
    check("restart_sop", out_startofpacket, 1);
    check("restart_data", out_data, 24'h000000);
    wait_fc(1, 200);

    check("chk_log_size", log2.size() >= 2 * 2 * W2, 1);
    check("chk_f0_31", log2[31], 24'h000000);
    check("chk_f0_32", log2[32], 24'hFFFFFF);
    check("chk_f1_31", log2[2 * W2 + 31], 24'hFFFFFF);
    for (int i = 0; i < 4 * W2; i++)
      check("chk_model", log2[i], model_pix(2, 0, i / (2 * W2), i % W2, (i / W2) % 2, W2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
